// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Four-input round-robin arbiter fused with a 4:1 data mux and a one-word
// output register. Each cycle the highest-priority requesting input, searched
// cyclically from the rotating pointer, is accepted (ack) whenever the output
// register is empty or being drained on the same edge. Sustains one word per
// cycle with no bubble under continuous demand.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   req[3:0]   : per-requester valid; req[i] means d<i> holds a word
//   d0..d3     : requester data words (WIDTH bits)
//   ack[3:0]   : combinational one-hot accept; d<i> is captured at this edge
//   out_ready  : downstream ready
//   out_valid  : registered; dout holds a valid word
//   dout       : registered selected word
//   sel[1:0]   : registered index of the requester whose word is in dout
//   gnt[3:0]   : registered one-hot form of sel, 0000 when out_valid=0
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       ack,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       sel,
  output logic [3:0]       gnt
);

  // The output register is either empty (IDLE) or full (BUSY); out_valid is
  // that single state bit driven straight from the flop.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic             load;
  logic [WIDTH-1:0] win_data;

  assign out_valid = (state == BUSY);

  // Cyclic priority search starting at ptr; first requester found wins.
  // NOTE: every variable written here gets a default first, otherwise paths
  // that skip an assignment would infer a latch.
  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Accept a new word when the output slot is free or drains this edge.
  assign load = rst_n && (req != 4'b0000) && (!out_valid || out_ready);

  always_comb begin
    ack = 4'b0000;
    if (load) ack[win] = 1'b1;
  end

  always_comb begin
    win_data = d0;
    case (win)
      2'd0: win_data = d0;
      2'd1: win_data = d1;
      2'd2: win_data = d2;
      2'd3: win_data = d3;
      default: win_data = d0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too, since a reset must leave dout
      // at zero and discard any held word.
      state <= IDLE;
      dout  <= '0;
      sel   <= 2'd0;
      gnt   <= 4'b0000;
      ptr   <= 2'd0;
    end else if (load) begin
      state <= BUSY;
      dout  <= win_data;
      sel   <= win;
      gnt   <= 4'b0001 << win;
      ptr   <= win + 2'd1;  // 2-bit add wraps 3 -> 0
    end else if (out_valid && out_ready) begin
      // Drained with nothing new to load; dout, sel and ptr keep their values.
      state <= IDLE;
      gnt   <= 4'b0000;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mux4_rr_arbiter. Directed stimulus pushes the expected output
// word (sel, gnt, dout) for each accepted request into a queue; a separate
// monitor pops and compares whenever the DUT completes an output transfer.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  localparam int WIDTH = 32;

  localparam logic [31:0] W0 = 32'hdeadbeef;
  localparam logic [31:0] W1 = 32'hfeedfeed;
  localparam logic [31:0] W2 = 32'haaaadddd;
  localparam logic [31:0] W3 = 32'hdadadada;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [3:0]       ack;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] dout;
  logic [1:0]       sel;
  logic [3:0]       gnt;

  typedef struct packed {
    logic [1:0]  sel;
    logic [3:0]  gnt;
    logic [31:0] dout;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int fails  = 0;

  mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .ack       (ack),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .dout      (dout),
    .sel       (sel),
    .gnt       (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected output word for requester i.
  function automatic exp_t mk(input int i);
    exp_t e;
    e.sel  = 2'(i);
    e.gnt  = 4'b0001 << i;
    case (i)
      0: e.dout = W0;
      1: e.dout = W1;
      2: e.dout = W2;
      default: e.dout = W3;
    endcase
    return e;
  endfunction

  // Check the combinational ack for an expected winner and queue its word.
  task automatic expect_load(input string name, input int i);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    check(name, 64'(ack), 64'(oh));
    exp_q.push_back(mk(i));
  endtask

  // Monitor: a transfer completes at the edge following a negedge where
  // out_valid && out_ready; compare against the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL xfer_unexpected: got sel=%0d dout=%0h expected none",
                 sel, dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("xfer", 64'({sel, gnt, dout}), 64'(e));
      end
    end
  end

  initial begin
    d0 = W0; d1 = W1; d2 = W2; d3 = W3;
    rst_n     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;

    // Reset held two edges with all requests active.
    #1;
    check("rst_ack0", 64'(ack), 64'(4'b0000));
    cyc();
    check("rst_ack1", 64'(ack), 64'(4'b0000));
    cyc();
    check("rst_ack2", 64'(ack), 64'(4'b0000));
    check("rst_valid", 64'(out_valid), 64'(1'b0));
    check("rst_dout", 64'(dout), 64'(32'h0));
    check("rst_sel", 64'(sel), 64'(2'b00));
    check("rst_gnt", 64'(gnt), 64'(4'b0000));
    rst_n = 1'b1;
    req   = 4'b0000;
    #1;
    check("idle_ack", 64'(ack), 64'(4'b0000));
    cyc();

    // Single requester 2.
    req = 4'b0100;
    #1;
    expect_load("single_ack", 2);
    cyc();
    req = 4'b0000;
    check("single_valid", 64'(out_valid), 64'(1'b1));
    cyc();
    check("drain_valid", 64'(out_valid), 64'(1'b0));
    check("drain_gnt", 64'(gnt), 64'(4'b0000));
    check("drain_dout_hold", 64'(dout), 64'(W2));

    // Reset to bring ptr back to 0, then full rotation.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      expect_load("rot_ack", k % 4);
      cyc();
    end
    // Last grant was 0, ptr=1: next load is requester 1 (feedfeed).
    #1;
    expect_load("rot_ack", 1);
    cyc();

    // Backpressure while holding feedfeed.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ack", 64'(ack), 64'(4'b0000));
      check("bp_hold", 64'({out_valid, sel, gnt, dout}),
            64'({1'b1, 2'b01, 4'b0010, W1}));
      cyc();
    end
    out_ready = 1'b1;
    #1;
    expect_load("bp_release_ack", 2);
    cyc();

    // Wrap: grant 3 so ptr returns to 0, then REQ=1001 twice.
    req = 4'b1000;
    #1;
    expect_load("wrap_pre_ack", 3);
    cyc();
    req = 4'b1001;
    #1;
    expect_load("wrap_ack0", 0);
    cyc();
    #1;
    expect_load("wrap_ack3", 3);
    cyc();

    // Reset mid-operation: load feedfeed, stall, then reset; the word must
    // never be transferred, so it is not queued.
    req = 4'b0010;
    #1;
    check("mid_load_ack", 64'(ack), 64'(4'b0010));
    cyc();
    out_ready = 1'b0;
    req       = 4'b0000;
    #1;
    check("mid_busy", 64'({out_valid, dout}), 64'({1'b1, W1}));
    rst_n = 1'b0;
    req   = 4'b1111;
    #1;
    check("mid_rst_ack", 64'(ack), 64'(4'b0000));
    cyc();
    check("mid_rst_state", 64'({out_valid, sel, gnt, dout}),
          64'({1'b0, 2'b00, 4'b0000, 32'h0}));
    rst_n     = 1'b1;
    req       = 4'b0000;
    out_ready = 1'b1;
    cyc();
    check("post_rst_idle", 64'(out_valid), 64'(1'b0));
    // ptr must be 0 after reset.
    req = 4'b1111;
    #1;
    expect_load("post_rst_ptr0", 0);
    cyc();
    req = 4'b0000;

    // Drain, bounded.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) cyc();
    cyc();
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    check("final_idle", 64'(out_valid), 64'(1'b0));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
